// File: rtl/ps2_pkg.sv
// Shared constants and types for the buffered PS/2 receive path.
package ps2_pkg;
  localparam logic PS2_START_BIT  = 1'b0;
  localparam logic PS2_STOP_BIT   = 1'b1;
  localparam int   PS2_FRAME_BITS = 11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam logic [3:0] PARITY_IDX = 4'd9;
  localparam logic [3:0] STOP_IDX   = 4'(PS2_FRAME_BITS - 1);

  typedef struct packed {
    logic parity;
    logic frame;
    logic timeout;
    logic overflow;
  } ps2_err_t;

  // Odd parity over the data byte plus the parity bit.
  function automatic logic ps2_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/ps2_rx_buffered_if.sv
// Scan-code handshake between the PS/2 receiver and the keyboard controller.
interface ps2_rx_buffered_if #(parameter int DEPTH = 4);
  logic                   rx_valid_o;
  logic                   rx_ready_i;
  logic [7:0]             scan_code_o;
  logic [$clog2(DEPTH):0] count_o;

  modport master (output rx_valid_o, scan_code_o, count_o, input rx_ready_i);
  modport slave  (input rx_valid_o, scan_code_o, count_o, output rx_ready_i);
endinterface

// File: rtl/ps2_rx_fifo.sv
// Show-ahead scan-code FIFO; a pop frees a full slot for a same-cycle push.
module ps2_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic [7:0]             wdata,
  input  logic                   pop,
  output logic [7:0]             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          push_ok, pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = cnt;
  assign rdata   = empty ? 8'h00 : mem[rptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/ps2_rx_buffered.sv
// PS/2 receiver: sync + de-glitch, 11-bit deframing with error checks,
// timeout of stalled frames, and a buffered valid/ready scan-code output.
module ps2_rx_buffered
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_din_i,
  ps2_rx_buffered_if.master rx,
  output logic err_parity_o,
  output logic err_frame_o,
  output logic err_timeout_o,
  output logic err_overflow_o,
  input  logic err_clr_i
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [1:0]            clk_sync, din_sync;
  logic [FILTER_LEN-1:0] flt_sh;
  logic                  filt, filt_d, fall_pulse, din;

  // Everything idles high so leaving reset can never look like a falling edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync   <= 2'b11;
      din_sync   <= 2'b11;
      flt_sh     <= '1;
      filt       <= 1'b1;
      filt_d     <= 1'b1;
      fall_pulse <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk_i};
      din_sync   <= {din_sync[0], ps2_din_i};
      flt_sh     <= {flt_sh[FILTER_LEN-2:0], clk_sync[1]};
      if (&flt_sh)       filt <= 1'b1;
      else if (~|flt_sh) filt <= 1'b0;
      filt_d     <= filt;
      fall_pulse <= filt_d & ~filt;
    end
  end

  assign din = din_sync[1];

  logic [0:0]    state;
  logic [3:0]    bitcnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    data;
  logic          parity;

  logic fifo_full, fifo_empty, pop;
  logic stop_evt, bad_stop, bad_par, ovf, push, tmo_evt;

  assign pop      = rx.rx_valid_o & rx.rx_ready_i;
  assign stop_evt = (state == ST_RECV) & fall_pulse & (bitcnt == STOP_IDX);
  assign bad_stop = stop_evt & (din != PS2_STOP_BIT);
  assign bad_par  = stop_evt & ~bad_stop & ~ps2_parity_ok(data, parity);
  assign ovf      = stop_evt & ~bad_stop & ~bad_par & fifo_full & ~pop;
  assign push     = stop_evt & ~bad_stop & ~bad_par & ~ovf;
  assign tmo_evt  = (state == ST_RECV) & ~fall_pulse & (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      bitcnt  <= '0;
      tmo_cnt <= '0;
      data    <= '0;
      parity  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall_pulse && din == PS2_START_BIT) begin
            state   <= ST_RECV;
            bitcnt  <= 4'd1;
            tmo_cnt <= '0;
          end
        end
        ST_RECV: begin
          if (fall_pulse) begin
            tmo_cnt <= '0;
            bitcnt  <= bitcnt + 4'd1;
            // Data arrives LSB first, so shift in from the top.
            if (bitcnt < PARITY_IDX)  data   <= {din, data[7:1]};
            if (bitcnt == PARITY_IDX) parity <= din;
            if (bitcnt == STOP_IDX) begin
              state  <= ST_IDLE;
              bitcnt <= '0;
            end
          end else if (tmo_evt) begin
            state   <= ST_IDLE;
            bitcnt  <= '0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ps2_err_t err_q, err_set;

  always_comb begin
    err_set          = '0;
    err_set.parity   = bad_par;
    err_set.frame    = bad_stop;
    err_set.timeout  = tmo_evt;
    err_set.overflow = ovf;
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= '0;
    else       err_q <= err_set | (err_q & ~{4{err_clr_i}});
  end

  assign err_parity_o   = err_q.parity;
  assign err_frame_o    = err_q.frame;
  assign err_timeout_o  = err_q.timeout;
  assign err_overflow_o = err_q.overflow;

  ps2_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (data),
    .pop   (pop),
    .rdata (rx.scan_code_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx.count_o)
  );

  assign rx.rx_valid_o = ~fifo_empty;
endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Bench for ps2_rx_buffered: directed table, corner sequences, random frames vs a queue model.
module tb_ps2_rx_buffered;
  localparam int FILTER_LEN = 4;
  localparam int DEPTH      = 4;
  localparam int TMO        = 400;
  localparam int H          = 20;

  logic clk = 1'b0;
  logic rst, pclk, din, clr;
  logic e_par, e_frm, e_tmo, e_ovf;
  int total = 0;
  int bad = 0;

  ps2_rx_buffered_if #(.DEPTH(DEPTH)) bus();

  ps2_rx_buffered #(.FILTER_LEN(FILTER_LEN), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .ps2_clk_i(pclk), .ps2_din_i(din), .rx(bus),
    .err_parity_o(e_par), .err_frame_o(e_frm), .err_timeout_o(e_tmo),
    .err_overflow_o(e_ovf), .err_clr_i(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         bp;
    bit         bs;
    int         exp_cnt;
    logic [3:0] exp_err;
  } vec_t;

  function automatic logic [3:0] errs();
    return {e_par, e_frm, e_tmo, e_ovf};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    din = b;
    tick(H / 2);
    pclk = 1'b0;
    tick(H);
    pclk = 1'b1;
    tick(H / 2);
  endtask

  task automatic pop1();
    bus.rx_ready_i = 1'b1;
    tick(1);
    bus.rx_ready_i = 1'b0;
  endtask

  task automatic clear_flags();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  // mode 1: check output latency of the stop bit; mode 2: pop exactly in the push cycle.
  task automatic send_frame(input logic [7:0] d, input bit bp, input bit bs, input int mode);
    logic p;
    p = ~(^d) ^ bp;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    din = ~bs;
    tick(H / 2);
    pclk = 1'b0;
    for (int i = 1; i <= H; i++) begin
      tick(1);
      if (mode == 1) begin
        if (i == FILTER_LEN + 4)     chk("lat_pre", int'(bus.rx_valid_o), 0);
        if (i == FILTER_LEN + 5) begin
          chk("lat_rise", int'(bus.rx_valid_o), 1);
          chk("lat_data", int'(bus.scan_code_o), int'(d));
        end
        if (i == FILTER_LEN + 6)     chk("lat_popped", int'(bus.rx_valid_o), 0);
      end
      if (mode == 2) begin
        if (i == FILTER_LEN + 4) bus.rx_ready_i = 1'b1;
        if (i == FILTER_LEN + 5) bus.rx_ready_i = 1'b0;
      end
    end
    pclk = 1'b1;
    tick(H / 2);
    din = 1'b1;
  endtask

  vec_t vecs[7];
  logic [7:0] mq[$];
  logic [3:0] m_err;

  initial begin
    rst = 1'b1; pclk = 1'b1; din = 1'b1; clr = 1'b0; bus.rx_ready_i = 1'b0;
    tick(3);
    chk("rst_valid", int'(bus.rx_valid_o), 0);
    chk("rst_count", int'(bus.count_o), 0);
    chk("rst_scan", int'(bus.scan_code_o), 0);
    chk("rst_err", int'(errs()), 0);
    rst = 1'b0;
    tick(2);

    // Two back-to-back frames with the consumer always ready.
    bus.rx_ready_i = 1'b1;
    send_frame(8'h1C, 0, 0, 1);
    send_frame(8'h15, 0, 0, 1);
    tick(5);
    chk("pair_count", int'(bus.count_o), 0);
    chk("pair_err", int'(errs()), 0);
    bus.rx_ready_i = 1'b0;

    // Parity error, clear, then a good frame.
    send_frame(8'h1C, 1, 0, 0);
    chk("par_count", int'(bus.count_o), 0);
    chk("par_flag", int'(e_par), 1);
    clear_flags();
    chk("par_clr", int'(errs()), 0);
    send_frame(8'h15, 0, 0, 0);
    chk("par_next_cnt", int'(bus.count_o), 1);
    chk("par_next_data", int'(bus.scan_code_o), 8'h15);
    chk("par_next_err", int'(errs()), 0);
    pop1();

    // Overflow: five frames into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 0);
    chk("ovf_count", int'(bus.count_o), 4);
    chk("ovf_flag", int'(e_ovf), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain", int'(bus.scan_code_o), i);
      pop1();
    end
    chk("ovf_empty", int'(bus.rx_valid_o), 0);
    clear_flags();

    // Full FIFO with a pop in the push cycle accepts the new entry.
    for (int i = 0; i < 4; i++) send_frame(8'(8'h11 + i), 0, 0, 0);
    send_frame(8'h15, 0, 0, 2);
    chk("fullpop_count", int'(bus.count_o), 4);
    chk("fullpop_ovf", int'(e_ovf), 0);
    for (int i = 0; i < 4; i++) begin
      chk("fullpop_drain", int'(bus.scan_code_o), 8'h12 + i);
      pop1();
    end

    // Stalled frame times out, next frame still arrives.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    tick(TMO - 60);
    chk("tmo_early", int'(e_tmo), 0);
    tick(160);
    chk("tmo_flag", int'(e_tmo), 1);
    chk("tmo_count", int'(bus.count_o), 0);
    clear_flags();
    send_frame(8'h15, 0, 0, 0);
    chk("tmo_next_data", int'(bus.scan_code_o), 8'h15);
    chk("tmo_next_err", int'(errs()), 0);
    pop1();

    // 3-cycle glitch with data low must not start a frame.
    din = 1'b0; pclk = 1'b0;
    tick(3);
    pclk = 1'b1; din = 1'b1;
    tick(10);
    chk("glitch_count", int'(bus.count_o), 0);
    send_frame(8'h1C, 0, 0, 0);
    chk("glitch_data", int'(bus.scan_code_o), 8'h1C);
    chk("glitch_err", int'(errs()), 0);
    pop1();
    send_frame(8'h1C, 0, 1, 0);
    chk("stop_flag", int'(e_frm), 1);
    chk("stop_count", int'(bus.count_o), 0);
    clear_flags();

    // Reset mid-frame with data buffered and a flag set.
    send_frame(8'h15, 0, 0, 0);
    send_frame(8'h33, 1, 0, 0);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_count", int'(bus.count_o), 0);
    chk("mrst_valid", int'(bus.rx_valid_o), 0);
    chk("mrst_err", int'(errs()), 0);
    tick(5);
    send_frame(8'h15, 0, 0, 0);
    chk("mrst_next_data", int'(bus.scan_code_o), 8'h15);
    chk("mrst_next_cnt", int'(bus.count_o), 1);
    pop1();

    // Directed table, consumer stalled.
    vecs[0] = '{8'h1C, 0, 0, 1, 4'b0000};
    vecs[1] = '{8'h15, 0, 0, 2, 4'b0000};
    vecs[2] = '{8'h1C, 1, 0, 2, 4'b1000};
    vecs[3] = '{8'h22, 0, 1, 2, 4'b1100};
    vecs[4] = '{8'h01, 0, 0, 3, 4'b1100};
    vecs[5] = '{8'h02, 0, 0, 4, 4'b1100};
    vecs[6] = '{8'h03, 0, 0, 4, 4'b1101};
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].bp, vecs[i].bs, 0);
      chk("tbl_count", int'(bus.count_o), vecs[i].exp_cnt);
      chk("tbl_err", int'(errs()), int'(vecs[i].exp_err));
    end
    chk("tbl_d0", int'(bus.scan_code_o), 8'h1C); pop1();
    chk("tbl_d1", int'(bus.scan_code_o), 8'h15); pop1();
    chk("tbl_d2", int'(bus.scan_code_o), 8'h01); pop1();
    chk("tbl_d3", int'(bus.scan_code_o), 8'h02); pop1();
    clear_flags();

    // Random frames against a queue model.
    m_err = '0;
    for (int n = 0; n < 14; n++) begin
      logic [7:0] d;
      int k, ndr;
      bit bp, bs;
      d  = 8'($urandom_range(0, 255));
      k  = $urandom_range(0, 4);
      bp = (k == 1) || (k == 3);
      bs = (k == 2) || (k == 3);
      send_frame(d, bp, bs, 0);
      if (bs)                    m_err[2] = 1'b1;
      else if (bp)               m_err[3] = 1'b1;
      else if (mq.size() == DEPTH) m_err[0] = 1'b1;
      else                       mq.push_back(d);
      chk("rnd_count", int'(bus.count_o), mq.size());
      chk("rnd_err", int'(errs()), int'(m_err));
      ndr = $urandom_range(0, mq.size());
      for (int j = 0; j < ndr; j++) begin
        chk("rnd_data", int'(bus.scan_code_o), int'(mq[0]));
        void'(mq.pop_front());
        pop1();
      end
    end
    while (mq.size() > 0) begin
      chk("rnd_tail", int'(bus.scan_code_o), int'(mq[0]));
      void'(mq.pop_front());
      pop1();
    end
    chk("rnd_empty", int'(bus.rx_valid_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
